// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types: shared types for the execute-stage branch resolution unit.
//   bp_state_t : resolution FSM states (BP_RUN, BP_REDIRECT)
//   bht_ctr_t  : 2-bit saturating branch history counter
//   BHT_INIT   : counter reset value (weakly not-taken)
//   bht_next() : saturating counter update
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic {
        BP_RUN      = 1'b0,
        BP_REDIRECT = 1'b1
    } bp_state_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_INIT = 2'b01;

    // Move toward 2'b11 on taken, toward 2'b00 on not-taken, sticking at the ends.
    function automatic bht_ctr_t bht_next(input bht_ctr_t cur, input logic taken);
        bht_ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_bht: bimodal branch history table of 2^IDX_W 2-bit counters.
// Ports:
//   clk, rst          clock, synchronous active-high reset (all entries -> BHT_INIT)
//   rd_idx_i          combinational lookup index
//   rd_taken_o        MSB of the looked-up counter (predict taken)
//   we_i              update strobe
//   wr_idx_i          index of the entry to update
//   wr_taken_i        resolved direction used for the update
// A read of the entry being written returns the pre-update value.
// -----------------------------------------------------------------------------
module branch_bht
    import rv32i_types::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_ctr_t ctr_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (we_i) begin
            ctr_q[wr_idx_i] <= bht_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

    assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve: execute-stage branch resolution and fetch redirect unit.
// Detects mispredicted conditional branches, issues a registered redirect to
// fetch with a ready/valid handshake, flushes younger stages while the
// redirect is pending, and counts resolved / mispredicted branches.
//
// Build option: BRANCH_BHT_EN
//   defined   : a bimodal BHT (branch_bht) provides if_pred_taken
//   undefined : no BHT storage, if_pred_taken is constant 0 (static not-taken)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_pc              fetch PC for prediction lookup
//   if_pred_taken      combinational prediction for if_pc
//   ex_valid/ex_is_br  EX holds a valid conditional branch
//   ex_br_en           comparator result (taken)
//   ex_pc/ex_target    branch PC and taken target
//   ex_pred_taken      prediction fetch made for this branch
//   ex_stall           EX held this cycle, nothing resolves
//   redir_valid/redir_pc/redir_ready  redirect handshake to fetch
//   flush              kill IF/ID and ID/EX
//   branch_cnt/mispred_cnt  event counters (wrap at 2^32)
// -----------------------------------------------------------------------------
module branch_resolve
    import rv32i_types::*;
#(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_br_en,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic        ex_stall,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        flush,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    bp_state_t   state_q, state_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] branch_cnt_q, mispred_cnt_q;

    logic        resolve;
    logic        mispredict;
    logic [31:0] correct_pc;

    // Resolution is only possible in RUN; while a redirect is pending the
    // EX contents are about to be flushed and must not train or count.
    assign resolve    = ex_valid & ex_is_br & ~ex_stall & (state_q == BP_RUN);
    assign mispredict = resolve & (ex_br_en != ex_pred_taken);
    assign correct_pc = ex_br_en ? ex_target : (ex_pc + 32'd4);

    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            BP_RUN: begin
                if (mispredict) begin
                    state_d    = BP_REDIRECT;
                    redir_pc_d = correct_pc;
                end
            end
            BP_REDIRECT: begin
                if (redir_ready) state_d = BP_RUN;
            end
            default: state_d = BP_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BP_RUN;
            redir_pc_q    <= 32'd0;
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            if (resolve)    branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign redir_valid = (state_q == BP_REDIRECT);
    assign flush       = (state_q == BP_REDIRECT);
    assign redir_pc    = redir_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

`ifdef BRANCH_BHT_EN
    // Only the word-index bits of the fetch PC address the table.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

    branch_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_pc[BHT_IDX_W+1:2]),
        .rd_taken_o (if_pred_taken),
        .we_i       (resolve),
        .wr_idx_i   (ex_pc[BHT_IDX_W+1:2]),
        .wr_taken_i (ex_br_en)
    );
`else
    // Static not-taken: no history, fetch PC and table size are irrelevant.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc, (BHT_IDX_W > 0)};
    assign if_pred_taken     = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    localparam int IDX_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_is_br, ex_br_en, ex_pred_taken, ex_stall;
    logic [31:0] ex_pc, ex_target;
    logic        redir_valid, redir_ready, flush;
    logic [31:0] redir_pc, branch_cnt, mispred_cnt;

    branch_resolve #(.BHT_IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_br      (ex_is_br),
        .ex_br_en      (ex_br_en),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_stall      (ex_stall),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .redir_ready   (redir_ready),
        .flush         (flush),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard entries: expected value with a tag, queued when stimulus is
    // applied and consumed when the corresponding DUT output is sampled.
    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [1:0]  m_bht [1 << IDX_W];
    logic [31:0] m_bc, m_mc;

    function automatic void push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endfunction

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_BHT_EN
        return m_bht[(pc >> 2) & ((1 << IDX_W) - 1)][1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < (1 << IDX_W); i++) m_bht[i] = 2'b01;
        m_bc = 32'd0;
        m_mc = 32'd0;
    endfunction

    task automatic check_state(input string tag, input logic rv);
        push({tag, "_redir_valid"}, {31'd0, rv});  chk({31'd0, redir_valid});
        push({tag, "_flush"},       {31'd0, rv});  chk({31'd0, flush});
        push({tag, "_branch_cnt"},  m_bc);         chk(branch_cnt);
        push({tag, "_mispred_cnt"}, m_mc);         chk(mispred_cnt);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        if_pc = pc;
        #1;
        push(tag, {31'd0, model_pred(pc)});
        chk({31'd0, if_pred_taken});
    endtask

    // Resolve one branch, checking the pre-update prediction for its own PC,
    // the post-edge outputs, and draining any resulting redirect.
    task automatic resolve_br(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic en, input logic pred);
        int          idx;
        logic        misp;
        logic [31:0] cpc;
        idx  = int'((pc >> 2) & ((1 << IDX_W) - 1));
        misp = (en != pred);
        cpc  = en ? tgt : pc + 32'd4;
        lookup({tag, "_pred_pre"}, pc);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc; ex_target = tgt;
        ex_br_en = en; ex_pred_taken = pred;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_br = 1'b0;
        m_bc++;
        if (misp) m_mc++;
        if (en && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
        else if (!en && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
        check_state(tag, misp);
        if (misp) begin
            push({tag, "_redir_pc"}, cpc);
            chk(redir_pc);
            redir_ready = 1'b1;
            @(posedge clk); #1;
            redir_ready = 1'b0;
            check_state({tag, "_drain"}, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; if_pc = 32'h100; ex_valid = 1'b0; ex_is_br = 1'b0; ex_br_en = 1'b0;
        ex_pc = 32'd0; ex_target = 32'd0; ex_pred_taken = 1'b0; ex_stall = 1'b0;
        redir_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_state("reset", 1'b0);
        push("reset_redir_pc", 32'd0); chk(redir_pc);
        lookup("reset_pred", 32'h100);

        // Non-branch and invalid instructions have no effect
        ex_valid = 1'b1; ex_is_br = 1'b0; ex_br_en = 1'b1; ex_pc = 32'h40; ex_target = 32'h80;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_br = 1'b1;
        @(posedge clk); #1;
        ex_is_br = 1'b0;
        check_state("nonbranch", 1'b0);

        // Not-taken, correctly predicted
        resolve_br("nt_ok", 32'h40, 32'h80, 1'b0, 1'b0);

        // Taken mispredict with fetch holding off the redirect for 3 cycles
        lookup("tk_pred_pre", 32'h40);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h40; ex_target = 32'h80;
        ex_br_en = 1'b1; ex_pred_taken = 1'b0;
        @(posedge clk); #1;
        m_bc++; m_mc++;
        m_bht[16] = (m_bht[16] == 2'b11) ? 2'b11 : m_bht[16] + 2'b01;
        // A different branch sits in EX during REDIRECT and must be ignored.
        ex_pc = 32'h200; ex_target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            check_state("hold", 1'b1);
            push("hold_redir_pc", 32'h80); chk(redir_pc);
            @(posedge clk); #1;
        end
        ex_valid = 1'b0; ex_is_br = 1'b0;
        redir_ready = 1'b1;
        @(posedge clk); #1;
        redir_ready = 1'b0;
        check_state("release", 1'b0);
        lookup("ignored_br_bht", 32'h200);

        // Train toward taken, then back down past the floor
        resolve_br("tk2", 32'h40, 32'h80, 1'b1, model_pred(32'h40));
        resolve_br("tk3", 32'h40, 32'h80, 1'b1, model_pred(32'h40));
        lookup("trained_taken", 32'h40);
        for (int i = 0; i < 4; i++) begin
            resolve_br("nt_train", 32'h40, 32'h80, 1'b0, model_pred(32'h40));
        end
        resolve_br("tk_after_floor", 32'h40, 32'h80, 1'b1, model_pred(32'h40));
        lookup("floor_held", 32'h40);

        // Stall holds a mispredicting branch: nothing happens until it drops
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = 32'h60; ex_target = 32'h10;
        ex_br_en = 1'b1; ex_pred_taken = 1'b0; ex_stall = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check_state("stall", 1'b0);
        end
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_stall = 1'b0;
        lookup("stall_no_bht", 32'h60);
        resolve_br("after_stall", 32'h60, 32'h10, 1'b1, model_pred(32'h60));

        // PC wrap on the fall-through path, then reset during REDIRECT
        lookup("wrap_pred_pre", 32'hFFFF_FFFC);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_target = 32'h1234;
        ex_br_en = 1'b0; ex_pred_taken = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_br = 1'b0;
        m_bc++; m_mc++;
        check_state("wrap", 1'b1);
        push("wrap_redir_pc", 32'h0000_0000); chk(redir_pc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_state("rst_in_redirect", 1'b0);
        push("rst_redir_pc", 32'd0); chk(redir_pc);
        lookup("rst_bht", 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
